// File: rtl/buffer_pkg.sv
// Shared definitions for the buffer slice.
//   FLOWS_W / flow_t   : flow ID width and type (also used by buffer_top)
//   MAX_BEATS          : default maximum packet length in beats
//   BEAT_CNT_W         : width of a counter that can hold MAX_BEATS
//   ingress_state_e    : state encoding of pkt_ingress_tagger
//   sat_inc            : saturating increment for statistics counters
package buffer_pkg;

  localparam int FLOWS_W    = 3;
  typedef logic [FLOWS_W-1:0] flow_t;

  localparam int MAX_BEATS  = 32;
  localparam int BEAT_CNT_W = $clog2(MAX_BEATS) + 1;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_HOLD0  = 3'd1,
    ST_STREAM = 3'd2,
    ST_FLUSH  = 3'd3,
    ST_DROP   = 3'd4
  } ingress_state_e;

  // Increment val, holding at the all-ones value of a width-bit counter.
  // Works on a 32-bit carrier so callers of any width up to 32 can share it.
  function automatic logic [31:0] sat_inc(input logic [31:0] val,
                                          input int unsigned width);
    logic [31:0] max_v;
    max_v = (width >= 32) ? 32'hFFFF_FFFF : ((32'd1 << width) - 32'd1);
    return (val >= max_v) ? max_v : (val + 32'd1);
  endfunction

endpackage

// File: rtl/pkt_ingress_tagger.sv
// pkt_ingress_tagger: tags an AXI-S packet stream with a flow ID taken from
// payload beat 1, truncates packets longer than MAX_BEATS and keeps
// saturating packet / truncation / runt statistics.
//
// Ports:
//   clk, resetn            clock, synchronous active-low reset
//   s_tdata/tvalid/tready/tlast   upstream packet stream (untagged)
//   m_tdata/tvalid/tready/tlast   downstream stream to the buffer write port
//   m_tsideband            flow ID, constant across each output packet
//   pkt_cnt/trunc_cnt/runt_cnt    saturating statistics
//   dbg_state_o            current FSM state
//
// Handshake: a beat transfers on a cycle where valid && ready are both high
// at the rising edge. A valid beat is never withdrawn or altered until it
// transfers; ready may depend combinationally on the other side's valid.
//
// Datapath: beat 0 waits in the hold register H until beat 1 reveals the
// flow ID, so every beat reaches the output register O one beat late and
// the sideband is already known when beat 0 leaves.
module pkt_ingress_tagger
  import buffer_pkg::*;
#(
  parameter int DATA_W       = 32,
  parameter int FLOWS_W      = 3,
  parameter int FLOW_LSB     = 0,
  parameter int MAX_BEATS    = 32,
  parameter int DEFAULT_FLOW = 0,
  parameter int CNT_W        = 16
) (
  input  logic               clk,
  input  logic               resetn,
  input  logic [DATA_W-1:0]  s_tdata,
  input  logic               s_tvalid,
  output logic               s_tready,
  input  logic               s_tlast,
  output logic [DATA_W-1:0]  m_tdata,
  output logic               m_tvalid,
  input  logic               m_tready,
  output logic               m_tlast,
  output logic [FLOWS_W-1:0] m_tsideband,
  output logic [CNT_W-1:0]   pkt_cnt,
  output logic [CNT_W-1:0]   trunc_cnt,
  output logic [CNT_W-1:0]   runt_cnt,
  output ingress_state_e     dbg_state_o
);

  localparam int BEAT_W = $clog2(MAX_BEATS) + 1;
  localparam logic [BEAT_W-1:0]  LAST_IDX = BEAT_W'(MAX_BEATS - 1);
  localparam logic [FLOWS_W-1:0] DEF_FLOW = FLOWS_W'(DEFAULT_FLOW);

  ingress_state_e     state_q, state_d;
  logic [DATA_W-1:0]  h_data_q, h_data_d;
  logic               h_last_q, h_last_d;
  logic [FLOWS_W-1:0] flow_q, flow_d;
  logic [DATA_W-1:0]  o_data_q, o_data_d;
  logic               o_valid_q, o_valid_d;
  logic               o_last_q, o_last_d;
  logic [FLOWS_W-1:0] o_sb_q, o_sb_d;
  logic [BEAT_W-1:0]  beat_q, beat_d;
  logic [CNT_W-1:0]   pkt_q, pkt_d;
  logic [CNT_W-1:0]   trunc_q, trunc_d;
  logic [CNT_W-1:0]   runt_q, runt_d;

  logic               out_free;
  logic               ready_int;
  logic               accept;
  logic [FLOWS_W-1:0] new_flow;
  logic [31:0]        pkt_inc, trunc_inc, runt_inc;

  assign out_free  = !o_valid_q || m_tready;
  // Held low during reset so no beat looks accepted while resetn is low.
  assign s_tready  = resetn && ready_int;
  assign accept    = s_tvalid && s_tready;
  assign new_flow  = s_tdata[FLOW_LSB +: FLOWS_W];

  assign pkt_inc   = sat_inc(32'(pkt_q),   CNT_W);
  assign trunc_inc = sat_inc(32'(trunc_q), CNT_W);
  assign runt_inc  = sat_inc(32'(runt_q),  CNT_W);

  always_comb begin
    state_d   = state_q;
    h_data_d  = h_data_q;
    h_last_d  = h_last_q;
    flow_d    = flow_q;
    o_data_d  = o_data_q;
    o_valid_d = o_valid_q;
    o_last_d  = o_last_q;
    o_sb_d    = o_sb_q;
    beat_d    = beat_q;
    pkt_d     = pkt_q;
    trunc_d   = trunc_q;
    runt_d    = runt_q;
    ready_int = 1'b0;

    // O empties when its beat is taken and nothing new is loaded below.
    if (out_free) o_valid_d = 1'b0;

    case (state_q)
      ST_IDLE: begin
        ready_int = out_free;
        if (accept) begin
          if (s_tlast) begin
            // Runt: no beat 1 to read a flow from, pass straight to O.
            o_valid_d = 1'b1;
            o_data_d  = s_tdata;
            o_last_d  = 1'b1;
            o_sb_d    = DEF_FLOW;
            runt_d    = runt_inc[CNT_W-1:0];
            pkt_d     = pkt_inc[CNT_W-1:0];
          end else begin
            h_data_d = s_tdata;
            h_last_d = 1'b0;
            state_d  = ST_HOLD0;
          end
        end
      end

      ST_HOLD0, ST_STREAM: begin
        ready_int = out_free;
        if (accept) begin
          o_valid_d = 1'b1;
          o_data_d  = h_data_q;
          if (state_q == ST_HOLD0) begin
            flow_d = new_flow;
            o_sb_d = new_flow;
          end else begin
            o_sb_d = flow_q;
          end
          beat_d = beat_q + BEAT_W'(1);
          if (!h_last_q && (beat_q == LAST_IDX)) begin
            // Beat MAX_BEATS-1 leaves without last: close the packet here,
            // throw away H and the beat arriving now, drain the remainder.
            o_last_d = 1'b1;
            trunc_d  = trunc_inc[CNT_W-1:0];
            pkt_d    = pkt_inc[CNT_W-1:0];
            state_d  = s_tlast ? ST_IDLE : ST_DROP;
          end else begin
            o_last_d = 1'b0;
            h_data_d = s_tdata;
            h_last_d = s_tlast;
            state_d  = s_tlast ? ST_FLUSH : ST_STREAM;
          end
        end
      end

      ST_FLUSH: begin
        ready_int = 1'b0;
        if (out_free) begin
          o_valid_d = 1'b1;
          o_data_d  = h_data_q;
          o_last_d  = 1'b1;
          o_sb_d    = flow_q;
          beat_d    = beat_q + BEAT_W'(1);
          pkt_d     = pkt_inc[CNT_W-1:0];
          state_d   = ST_IDLE;
        end
      end

      ST_DROP: begin
        ready_int = 1'b1;
        if (accept && s_tlast) state_d = ST_IDLE;
      end

      default: state_d = ST_IDLE;
    endcase

    if (state_d == ST_IDLE) beat_d = '0;
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q   <= ST_IDLE;
      h_data_q  <= '0;
      h_last_q  <= 1'b0;
      flow_q    <= '0;
      o_data_q  <= '0;
      o_valid_q <= 1'b0;
      o_last_q  <= 1'b0;
      o_sb_q    <= '0;
      beat_q    <= '0;
      pkt_q     <= '0;
      trunc_q   <= '0;
      runt_q    <= '0;
    end else begin
      state_q   <= state_d;
      h_data_q  <= h_data_d;
      h_last_q  <= h_last_d;
      flow_q    <= flow_d;
      o_data_q  <= o_data_d;
      o_valid_q <= o_valid_d;
      o_last_q  <= o_last_d;
      o_sb_q    <= o_sb_d;
      beat_q    <= beat_d;
      pkt_q     <= pkt_d;
      trunc_q   <= trunc_d;
      runt_q    <= runt_d;
    end
  end

  assign m_tdata     = o_data_q;
  assign m_tvalid    = o_valid_q;
  assign m_tlast     = o_last_q;
  assign m_tsideband = o_sb_q;
  assign pkt_cnt     = pkt_q;
  assign trunc_cnt   = trunc_q;
  assign runt_cnt    = runt_q;
  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_pkt_ingress_tagger.sv
// Bench for pkt_ingress_tagger: directed packet table, random back-to-back
// traffic with random downstream stalls, mid-packet reset and counter
// saturation on a second CNT_W=4 instance fed with the same stimulus.
module tb_pkt_ingress_tagger;

  localparam int DW    = 32;
  localparam int EXP_W = 3 + 1 + DW;  // {sideband, last, data}

  logic          clk;
  logic          resetn;
  logic [DW-1:0] s_tdata;
  logic          s_tvalid;
  logic          s_tlast;
  logic          m_tready;

  logic          s_tready, m_tvalid, m_tlast;
  logic [DW-1:0] m_tdata;
  logic [2:0]    m_tsideband;
  logic [15:0]   pkt_cnt, trunc_cnt, runt_cnt;
  buffer_pkg::ingress_state_e dbg_state;

  logic          s_tready4, m_tvalid4, m_tlast4;
  logic [DW-1:0] m_tdata4;
  logic [2:0]    m_tsideband4;
  logic [3:0]    pkt_cnt4, trunc_cnt4, runt_cnt4;
  buffer_pkg::ingress_state_e dbg_state4;

  pkt_ingress_tagger dut (
    .clk(clk), .resetn(resetn),
    .s_tdata(s_tdata), .s_tvalid(s_tvalid), .s_tready(s_tready), .s_tlast(s_tlast),
    .m_tdata(m_tdata), .m_tvalid(m_tvalid), .m_tready(m_tready), .m_tlast(m_tlast),
    .m_tsideband(m_tsideband),
    .pkt_cnt(pkt_cnt), .trunc_cnt(trunc_cnt), .runt_cnt(runt_cnt),
    .dbg_state_o(dbg_state)
  );

  pkt_ingress_tagger #(.CNT_W(4)) dut4 (
    .clk(clk), .resetn(resetn),
    .s_tdata(s_tdata), .s_tvalid(s_tvalid), .s_tready(s_tready4), .s_tlast(s_tlast),
    .m_tdata(m_tdata4), .m_tvalid(m_tvalid4), .m_tready(m_tready), .m_tlast(m_tlast4),
    .m_tsideband(m_tsideband4),
    .pkt_cnt(pkt_cnt4), .trunc_cnt(trunc_cnt4), .runt_cnt(runt_cnt4),
    .dbg_state_o(dbg_state4)
  );

  // ---------------- clock ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- bookkeeping ----------------
  int n_cmp  = 0;
  int n_fail = 0;
  logic [EXP_W-1:0] exp_q[$];
  bit   mon_en   = 1'b0;
  bit   rand_rdy = 1'b0;
  int   out_beats = 0;
  int   late_stalls;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic report();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
  endtask

  function automatic logic [DW-1:0] beat_data(input int pkt, input int i, input int flow);
    logic [2:0] low;
    low = (i == 1) ? 3'(flow) : 3'(i);
    return {8'(pkt), 16'(i), 5'd0, low};
  endfunction

  // ---------------- downstream ready ----------------
  initial begin
    m_tready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      m_tready = rand_rdy ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  end

  // ---------------- output monitor / scoreboard ----------------
  initial begin
    logic [EXP_W-1:0] prev_o;
    logic [EXP_W-1:0] e;
    bit prev_stall;
    prev_stall = 1'b0;
    prev_o     = '0;
    forever begin
      @(negedge clk);
      if (!mon_en || !resetn) begin
        prev_stall = 1'b0;
        continue;
      end
      if (prev_stall)
        check("stall_hold", 64'({m_tvalid, m_tsideband, m_tlast, m_tdata}),
              64'({1'b1, prev_o}));
      if (m_tvalid && m_tready) begin
        out_beats++;
        if (exp_q.size() == 0) begin
          n_cmp++;
          n_fail++;
          $display("FAIL unexpected_beat: got %0h expected none", {m_tsideband, m_tlast, m_tdata});
        end else begin
          e = exp_q.pop_front();
          check("out_beat", 64'({m_tsideband, m_tlast, m_tdata}), 64'(e));
        end
      end
      prev_stall = m_tvalid && !m_tready;
      prev_o     = {m_tsideband, m_tlast, m_tdata};
    end
  end

  // ---------------- driver tasks ----------------
  task automatic send_beat(input logic [DW-1:0] d, input logic l, output int stalls);
    s_tdata  = d;
    s_tlast  = l;
    s_tvalid = 1'b1;
    stalls   = 0;
    forever begin
      @(negedge clk);
      if (s_tready) begin
        @(posedge clk);
        #1;
        break;
      end
      stalls++;
      if (stalls > 500) begin
        n_cmp++;
        n_fail++;
        $display("FAIL accept_timeout: got no s_tready expected accept within 500 cycles");
        break;
      end
    end
  endtask

  task automatic send_pkt(input int pkt, input int len, input int flow);
    int st;
    late_stalls = 0;
    for (int i = 0; i < len; i++) begin
      send_beat(beat_data(pkt, i, flow), (i == len - 1), st);
      if (i >= 32) late_stalls += st;
    end
    s_tvalid = 1'b0;
    s_tlast  = 1'b0;
  endtask

  task automatic push_exp(input int pkt, input int flow, input int n_out, input int sb);
    for (int i = 0; i < n_out; i++)
      exp_q.push_back({3'(sb), (i == n_out - 1), beat_data(pkt, i, flow)});
  endtask

  task automatic drain();
    int t;
    t = 0;
    while (exp_q.size() != 0 && t < 3000) begin
      @(posedge clk);
      t++;
    end
    if (exp_q.size() != 0) begin
      n_cmp++;
      n_fail++;
      $display("FAIL drain_timeout: got %0d beats left expected 0", exp_q.size());
      exp_q.delete();
    end
    repeat (3) @(posedge clk);
    #1;
  endtask

  // ---------------- directed table ----------------
  typedef struct {
    int len;
    int flow;
    int exp_beats;
    int exp_sb;
    int exp_pkt;
    int exp_trunc;
    int exp_runt;
  } vec_t;

  vec_t vecs[8];

  // ---------------- watchdog ----------------
  initial begin
    #400000;
    $display("FAIL watchdog: got timeout expected $finish");
    n_fail++;
    report();
    $fatal(1, "watchdog expired");
  end

  // ---------------- main sequence ----------------
  initial begin
    int b_pkt, b_trunc, b_runt, b_beats, exp_sum;
    int len, fl;

    vecs[0] = '{32, 5, 32, 5, 1, 0, 0};  // exactly MAX_BEATS: not truncated
    vecs[1] = '{40, 3, 32, 3, 1, 1, 0};  // truncated, 8 beats dropped
    vecs[2] = '{20, 7, 20, 7, 1, 0, 0};  // packet after truncation
    vecs[3] = '{ 1, 4,  1, 0, 1, 0, 1};  // runt gets DEFAULT_FLOW
    vecs[4] = '{ 2, 2,  2, 2, 1, 0, 0};  // 2-beat packet after runt
    vecs[5] = '{33, 1, 32, 1, 1, 1, 0};  // last arrives on the truncating cycle
    vecs[6] = '{31, 6, 31, 6, 1, 0, 0};
    vecs[7] = '{ 3, 0,  3, 0, 1, 0, 0};

    resetn   = 1'b0;
    s_tvalid = 1'b0;
    s_tdata  = '0;
    s_tlast  = 1'b0;
    repeat (3) @(posedge clk);
    #1;

    check("rst_m_tvalid", 64'(m_tvalid), 64'(0));
    check("rst_m_tdata", 64'(m_tdata), 64'(0));
    check("rst_m_tlast", 64'(m_tlast), 64'(0));
    check("rst_m_tsideband", 64'(m_tsideband), 64'(0));
    check("rst_s_tready", 64'(s_tready), 64'(0));
    check("rst_pkt_cnt", 64'(pkt_cnt), 64'(0));
    check("rst_trunc_cnt", 64'(trunc_cnt), 64'(0));
    check("rst_runt_cnt", 64'(runt_cnt), 64'(0));
    check("rst_state", 64'(dbg_state), 64'(buffer_pkg::ST_IDLE));

    resetn = 1'b1;
    mon_en = 1'b1;
    @(posedge clk);
    #1;
    check("idle_s_tready", 64'(s_tready), 64'(1));

    for (int v = 0; v < 8; v++) begin
      b_pkt   = pkt_cnt;
      b_trunc = trunc_cnt;
      b_runt  = runt_cnt;
      b_beats = out_beats;
      push_exp(v + 1, vecs[v].flow, vecs[v].exp_beats, vecs[v].exp_sb);
      send_pkt(v + 1, vecs[v].len, vecs[v].flow);
      drain();
      check($sformatf("vec%0d_beats", v), 64'(out_beats - b_beats), 64'(vecs[v].exp_beats));
      check($sformatf("vec%0d_pkt", v), 64'(pkt_cnt - b_pkt), 64'(vecs[v].exp_pkt));
      check($sformatf("vec%0d_trunc", v), 64'(trunc_cnt - b_trunc), 64'(vecs[v].exp_trunc));
      check($sformatf("vec%0d_runt", v), 64'(runt_cnt - b_runt), 64'(vecs[v].exp_runt));
      check($sformatf("vec%0d_drop_ready", v), 64'(late_stalls), 64'(0));
    end
    check("table_pkt_total", 64'(pkt_cnt), 64'(8));
    check("table_trunc_total", 64'(trunc_cnt), 64'(2));
    check("table_runt_total", 64'(runt_cnt), 64'(1));

    // Random back-to-back packets with random downstream stalls.
    rand_rdy = 1'b1;
    b_pkt    = pkt_cnt;
    b_beats  = out_beats;
    exp_sum  = 0;
    for (int p = 0; p < 64; p++) begin
      len = $urandom_range(16, 32);
      fl  = $urandom_range(0, 7);
      exp_sum += len;
      push_exp(100 + p, fl, len, fl);
      send_pkt(100 + p, len, fl);
    end
    drain();
    rand_rdy = 1'b0;
    check("rand_pkt_cnt", 64'(pkt_cnt - b_pkt), 64'(64));
    check("rand_beats", 64'(out_beats - b_beats), 64'(exp_sum));
    check("rand_trunc_cnt", 64'(trunc_cnt), 64'(2));

    // Reset pulse during beat 10 of a 30-beat packet.
    mon_en = 1'b0;
    for (int i = 0; i < 10; i++) begin
      int st;
      send_beat(beat_data(200, i, 2), 1'b0, st);
    end
    s_tdata  = beat_data(200, 10, 2);
    s_tvalid = 1'b1;
    resetn   = 1'b0;
    @(posedge clk);
    #1;
    check("mid_rst_m_tvalid", 64'(m_tvalid), 64'(0));
    check("mid_rst_m_tdata", 64'(m_tdata), 64'(0));
    check("mid_rst_m_tlast", 64'(m_tlast), 64'(0));
    check("mid_rst_m_tsideband", 64'(m_tsideband), 64'(0));
    check("mid_rst_s_tready", 64'(s_tready), 64'(0));
    check("mid_rst_pkt_cnt", 64'(pkt_cnt), 64'(0));
    check("mid_rst_trunc_cnt", 64'(trunc_cnt), 64'(0));
    check("mid_rst_runt_cnt", 64'(runt_cnt), 64'(0));
    s_tvalid = 1'b0;
    resetn   = 1'b1;
    exp_q.delete();
    mon_en   = 1'b1;
    b_beats  = out_beats;
    push_exp(201, 6, 12, 6);
    send_pkt(201, 12, 6);
    drain();
    check("post_rst_beats", 64'(out_beats - b_beats), 64'(12));
    check("post_rst_pkt_cnt", 64'(pkt_cnt), 64'(1));
    check("post_rst_pkt_cnt4", 64'(pkt_cnt4), 64'(1));

    // Saturation on the CNT_W=4 instance: 20 runts on top of 1 packet.
    for (int k = 1; k <= 20; k++) begin
      push_exp(210 + k, 0, 1, 0);
      send_pkt(210 + k, 1, 0);
      drain();
      check($sformatf("sat_pkt_cnt4_%0d", k), 64'(pkt_cnt4), 64'((1 + k > 15) ? 15 : 1 + k));
    end
    check("sat_runt_cnt4", 64'(runt_cnt4), 64'(15));
    check("sat_pkt_cnt16", 64'(pkt_cnt), 64'(21));
    check("sat_runt_cnt16", 64'(runt_cnt), 64'(20));

    report();
    $finish;
  end

endmodule

// File: doc/pkt_ingress_tagger.md
Name: pkt_ingress_tagger

Overview:
Ingress stage placed directly upstream of buffer_top's write port. It takes an untagged AXI-S packet stream and extracts the flow ID from payload beat 1, so it can drive the sideband with that flow ID from beat 0 onward. It enforces a maximum packet length by truncating and discarding the excess. It keeps saturating statistics counters for packets, truncations and runts.

Parameters:
DATA_W, 32, data width in bits
FLOWS_W, 3, flow ID width; equals the buffer's SB_WIDTH
FLOW_LSB, 0, bit position of the flow field inside beat 1
MAX_BEATS, 32, maximum beats per output packet (128 B at 32-bit data)
DEFAULT_FLOW, 0, flow assigned to single-beat (runt) packets
CNT_W, 16, statistics counter width

Ports:
clk  in  1  clock
resetn  in  1  synchronous active-low reset
s_tdata  in  DATA_W  upstream data
s_tvalid  in  1  upstream valid
s_tready  out  1  upstream ready
s_tlast  in  1  upstream end of packet
m_tdata  out  DATA_W  data to buffer s_wdata
m_tvalid  out  1  valid to buffer
m_tready  in  1  ready from buffer
m_tlast  out  1  end of packet to buffer
m_tsideband  out  FLOWS_W  flow ID, constant for the whole packet
pkt_cnt  out  CNT_W  packets emitted (saturating)
trunc_cnt  out  CNT_W  packets truncated (saturating)
runt_cnt  out  CNT_W  single-beat packets (saturating)

Behaviour:
- Reset: all outputs are 0. State is IDLE, the hold register is invalid and the beat counter is 0. Reset mid-packet abandons the packet; the first beat after reset is treated as beat 0.
- Datapath: a hold register H (data, last) feeds an output register O (m_t*). Define out_free = !m_tvalid || m_tready. O changes only when out_free is high. m_t* are stable while m_tvalid && !m_tready.
- States: IDLE, HOLD0, STREAM, FLUSH, DROP.
- IDLE: s_tready = out_free.
  - Accepted beat with s_tlast=1 (runt): load O with sideband DEFAULT_FLOW and last=1; increment runt_cnt and pkt_cnt; stay in IDLE.
  - Otherwise: store the beat in H and go to HOLD0.
- HOLD0: s_tready = out_free.
  - On accept (beat 1): latch flow = s_tdata[FLOW_LSB +: FLOWS_W] into the sideband register.
  - Move H (beat 0) to O with that sideband.
  - Store beat 1 in H.
  - Next state is FLUSH if s_tlast, else STREAM.
- STREAM: s_tready = out_free.
  - Each accepted beat moves H to O and loads the new beat into H.
  - Go to FLUSH when the newly held beat has last=1.
- FLUSH: s_tready = 0. When out_free is high, move H to O with m_tlast=1, increment pkt_cnt, and go to IDLE.
- Beat counter: counts beats loaded into O for the current packet and clears on entry to IDLE.
- Truncation: when the beat being loaded into O is beat MAX_BEATS-1 and its own last=0:
  - force m_tlast=1;
  - discard H;
  - increment trunc_cnt and pkt_cnt;
  - if the beat accepted in that same cycle had s_tlast=1, go to IDLE, otherwise go to DROP.
- DROP: s_tready = 1, m_tvalid is not driven new, and input beats are discarded until an accepted s_tlast, then go to IDLE.
- A packet of exactly MAX_BEATS beats is not truncated.
- Latency: beat 0 reaches O one cycle after beat 1 is accepted.
- Throughput: 1 beat/cycle in STREAM. There is one bubble per packet (FLUSH) and no bubble for runts.
- Counters saturate at 2^CNT_W-1 and never wrap.
- Sideband is constant from the first to the last output beat of a packet. Upstream data order is preserved exactly.

Decomposition:
- Shared package buffer_pkg holds:
  - FLOWS_W and the flow_t typedef (shared with buffer_top);
  - the ingress state enum typedef;
  - localparam BEAT_CNT_W = $clog2(MAX_BEATS)+1.
- No sub-module; the saturating counter is a small function in buffer_pkg.

Test Plan:
- 32-beat packet, beat1[2:0]=5, m_tready=1 -> 32 output beats, all m_tsideband=5, m_tlast only on beat 31, data identical, pkt_cnt=1.
- 40-beat packet, flow 3 -> 32 beats output, m_tlast forced on beat 31, 8 input beats consumed with s_tready=1 and no output, trunc_cnt=1, next packet tagged correctly.
- Single beat with s_tlast=1 -> 1 output beat, sideband=0, m_tlast=1, runt_cnt=1; a 2-beat packet follows and is tagged from its beat 1.
- 64 back-to-back packets of 16-32 beats with random flows, m_tready random per cycle -> no loss or reorder, m_t* stable under stall, sideband matches per packet, pkt_cnt=64.
- resetn pulsed low for 1 cycle on beat 10 of a 30-beat packet -> all outputs 0 during reset; the next packet (flow 6) is emitted intact with sideband 6.
- pkt_cnt forced near saturation (CNT_W=4 build, 20 packets) -> pkt_cnt holds at 15.
